// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_sweep_checker
// Description : Drives the four (a,b) vectors into a 2-input gate under test,
//               samples c at the end of each dwell period and counts mismatches
//               against EXPECT. Optional early stop on the first mismatch is
//               enabled by defining GATE_SWEEP_STOP_ON_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_checker #(
    parameter int unsigned DWELL  = 100,
    parameter logic [3:0]  EXPECT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] C_LAST_CNT = 16'(DWELL - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  err_q, err_d;
    logic        a_q, a_d;
    logic        b_q, b_d;
    logic        w_mismatch;
    logic        w_stop_now;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        w_mismatch = 1'b0;
        w_stop_now = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 16'd0;
                    idx_d   = 2'd0;
                    err_d   = 3'd0;
                end
            end
            RUN: begin
                if (cnt_q == C_LAST_CNT) begin
                    // c is only observed on this single edge of each dwell
                    w_mismatch = (c != EXPECT[idx_q]);
                    if (w_mismatch && (err_q != 3'd4)) begin
                        err_d = err_q + 3'd1;
                    end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
                    w_stop_now = w_mismatch;
`else
                    w_stop_now = 1'b0;
`endif
                    if (w_stop_now || (idx_q == 2'd3)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        cnt_d = 16'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from the next index so vector k appears on RUN's first cycle
        a_d = (state_d == RUN) & idx_d[0];
        b_d = (state_d == RUN) & idx_d[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 2'd0;
            err_q   <= 3'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == 3'd0);
    assign err_count = err_q;
    assign vec_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_sweep_checker
// Description : Directed self-checking bench for gate_sweep_checker, DWELL=4,
//               gate under test modelled by the bench driving c.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] vec_idx;

    int n_checks;
    int n_fail;

    gate_sweep_checker #(
        .DWELL  (4),
        .EXPECT (4'b1000)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_idx   (vec_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode 0: AND gate, 1: tied 0, 2: tied 1, 3: AND only at dwell end, inverted otherwise
    function automatic logic gate_c(input int mode, input int k, input int ph);
        logic and_out;
        and_out = (k == 3);
        case (mode)
            0:       gate_c = and_out;
            1:       gate_c = 1'b0;
            2:       gate_c = 1'b1;
            default: gate_c = (ph == 3) ? and_out : ~and_out;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; c = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, done, pass, a, b, err_count, vec_idx} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b a=%b b=%b err=%0d idx=%0d, want all 0",
                     busy, done, pass, a, b, err_count, vec_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_sweep();
        start = 1'b1; c = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = gate_c(3, i / 4, i % 4);
            n_checks++;
            if (busy !== 1'b1 || a !== ((i / 4) % 2 == 1) || b !== (i / 4 >= 2)) begin
                n_fail++;
                $display("FAIL full_vector cyc %0d: got busy=%b a=%b b=%b, want busy=1 a=%b b=%b",
                         i, busy, a, b, ((i / 4) % 2 == 1), (i / 4 >= 2));
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0 ||
            vec_idx !== 2'd3 || a !== 1'b0 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: got busy=%b done=%b pass=%b err=%0d idx=%0d a=%b b=%b, want 0 1 1 0 3 0 0",
                     busy, done, pass, err_count, vec_idx, a, b);
        end
    endtask

    task automatic test_tied_low();
        start = 1'b1; c = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd1 || vec_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL tied_low: got done=%b pass=%b err=%0d idx=%0d, want 1 0 1 3",
                     done, pass, err_count, vec_idx);
        end
    endtask

    task automatic test_tied_high();
        int busy_cycles;
        busy_cycles = 0;
        start = 1'b1; c = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            busy_cycles++;
            tick();
        end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        n_checks++;
        if (busy_cycles != 4 || done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd1 || vec_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL tied_high_stop: got busy_cycles=%0d done=%b pass=%b err=%0d idx=%0d, want 4 1 0 1 0",
                     busy_cycles, done, pass, err_count, vec_idx);
        end
`else
        n_checks++;
        if (busy_cycles != 16 || done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd3 || vec_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL tied_high: got busy_cycles=%0d done=%b pass=%b err=%0d idx=%0d, want 16 1 0 3 3",
                     busy_cycles, done, pass, err_count, vec_idx);
        end
`endif
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; start = 1'b1; c = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first_busy cyc %0d: got %b, want 1", i, busy);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || err_count !== 3'd1 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_done: got done=%b busy=%b err=%0d pass=%b, want 1 0 1 0",
                     done, busy, err_count, pass);
        end
        c = gate_c(0, 0, 0);
        tick();
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== 3'd0 || vec_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b done=%b err=%0d idx=%0d, want 1 0 0 0",
                     busy, done, err_count, vec_idx);
        end
        for (int i = 0; i < 16; i++) begin
            c = gate_c(0, i / 4, i % 4);
            if (i == 6) start = 1'b0;
            n_checks++;
            if (busy !== 1'b1 || vec_idx !== 2'(i / 4)) begin
                n_fail++;
                $display("FAIL b2b_second cyc %0d: got busy=%b idx=%0d, want 1 %0d", i, busy, vec_idx, i / 4);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done=%b pass=%b err=%0d, want 1 1 0", done, pass, err_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b1; c = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = gate_c(0, i / 4, i % 4);
            tick();
        end
        n_checks++;
        if (busy !== 1'b1 || vec_idx !== 2'd1 || a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_reset: got busy=%b idx=%0d a=%b, want 1 1 1", busy, vec_idx, a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, pass, a, b, err_count, vec_idx} !== 10'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b done=%b pass=%b a=%b b=%b err=%0d idx=%0d, want all 0",
                     busy, done, pass, a, b, err_count, vec_idx);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stays_idle: got busy=%b, want 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = gate_c(0, i / 4, i % 4);
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0 || vec_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_resweep: got done=%b pass=%b err=%0d idx=%0d, want 1 1 0 3",
                     done, pass, err_count, vec_idx);
        end
    endtask

    task automatic test_rst_and_start();
        rst = 1'b1; start = 1'b1; c = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_same: got busy=%b done=%b, want 0 0", busy, done);
        end
        rst = 1'b0; start = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_no_sweep: got busy=%b, want 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || a !== 1'b0 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_recur: got busy=%b a=%b b=%b, want 1 0 0", busy, a, b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; c = 1'b0;
        #1;
        test_reset();
        test_full_sweep();
        test_tied_low();
        test_tied_high();
        test_back_to_back();
        test_reset_mid_sweep();
        test_rst_and_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter DWELL, default 100: clock cycles each input vector is held before c is sampled; legal range 2..65535.
REQ-002 Parameter EXPECT, default 4'b1000: expected c per vector index k (bit k); the default is the 2-input AND truth table.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a sweep; sampled each rising edge.
REQ-006 a  output  1  gate input A driven to the downstream gate under test.
REQ-007 b  output  1  gate input B driven to the downstream gate under test.
REQ-008 c  input  1  gate under test output; sampled only at dwell end.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  level, high while a finished sweep's result is held.
REQ-011 pass  output  1  high with done when err_count == 0.
REQ-012 err_count  output  3  number of mismatching vectors in the current or last sweep (0..4).
REQ-013 vec_idx  output  2  index k of the vector currently or last driven.

Function
REQ-014 Vector k drives a = k[0] and b = k[1], in order k = 0,1,2,3, i.e. (a,b) = 00, 10, 01, 11.
REQ-015 The FSM shall have states IDLE, RUN and DONE, with IDLE entered on reset.
REQ-016 IDLE or DONE with start=1 -> RUN on the next edge: vec_idx=0, dwell counter=0, err_count=0, busy=1, done=0, pass=0.
REQ-017 In RUN, a/b shall be registered from vec_idx, so the first RUN cycle already shows vector 0.
REQ-018 The dwell counter shall increment every RUN cycle; at count == DWELL-1, c shall be compared with EXPECT[vec_idx] on that edge.
REQ-019 A mismatch shall increment err_count by 1 on the sampling edge; err_count saturates at 4.
REQ-020 At dwell end with vec_idx < 3: vec_idx += 1 and counter = 0; vec_idx never wraps within a sweep.
REQ-021 At dwell end with vec_idx == 3: -> DONE; busy=0, done=1, pass=(final err_count==0), all on the same edge.
REQ-022 A full sweep shall keep busy high for exactly 4*DWELL cycles.
REQ-023 In IDLE and DONE, a=0 and b=0; vec_idx and err_count hold their last values in DONE.
REQ-024 start while in RUN shall be ignored; a start held high continuously shall restart only after DONE is reached.
REQ-025 c shall be ignored in all cycles other than the sampling edges.

Reset
REQ-026 rst=1 on an edge shall force IDLE with a=0, b=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0 and counter=0, regardless of state.
REQ-027 rst shall take priority over start on the same edge; reset mid-sweep shall discard the partial result.

Configuration
REQ-028 Macro GATE_SWEEP_STOP_ON_ERR_EN defined: the first mismatch -> DONE on that sampling edge, with err_count=1, pass=0, and vec_idx holding the failing index.
REQ-029 Macro GATE_SWEEP_STOP_ON_ERR_EN undefined: all four vectors are always run, and the macro shall have no other effect.

Verification (bench with DWELL=4, AND gate under test unless stated)
REQ-030 rst 2 cycles, then start 1 cycle -> (a,b) = 00,10,01,11 for 4 cycles each, busy 16 cycles, then done=1, pass=1, err_count=0, vec_idx=3.
REQ-031 c tied 0 -> err_count=1 (k=3), pass=0; c tied 1 -> err_count=3, pass=0.
REQ-032 c tied 1 with GATE_SWEEP_STOP_ON_ERR_EN -> done after 4 busy cycles, vec_idx=0, err_count=1, pass=0.
REQ-033 start held high from cycle 0 -> exactly one 16-cycle sweep, then an immediate restart with err_count cleared to 0 on the DONE->RUN edge.
REQ-034 rst asserted during busy cycle 6 -> next edge all outputs 0, IDLE; a subsequent start yields a full passing sweep.
REQ-035 rst and start high on the same edge -> IDLE, busy=0; no sweep starts until start recurs with rst low.
